// File: rtl/pio_in_edge.sv
// Avalon-MM edge-capture input port: synchronised inputs, edgecapture with
// write-1-to-clear, interrupt mask and level irq. Optional filter: PIO_IN_DEBOUNCE_EN.
module pio_in_edge #(
   parameter int WIDTH           = 8,
   parameter int EDGE_TYPE       = 0,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("pio_in_edge: WIDTH out of range 1..32");
   end
   if (EDGE_TYPE < 0 || EDGE_TYPE > 2) begin : g_bad_edge
      $error("pio_in_edge: EDGE_TYPE must be 0, 1 or 2");
   end
   if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_db
      $error("pio_in_edge: DEBOUNCE_CYCLES out of range 2..65535");
   end

   logic [WIDTH-1:0] s1_q, s2_q, prev_q;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] ec_q, ec_d;
   logic [31:0]      rd_d;
   logic [WIDTH-1:0] cond_s;
   logic [WIDTH-1:0] edge_s;
   logic             wr_en_s;
   logic             unused_wdata;

   assign unused_wdata = ^writedata;

`ifdef PIO_IN_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [CW-1:0]    cnt_q [WIDTH];
   logic [CW-1:0]    cnt_d [WIDTH];
   logic [WIDTH-1:0] filt_q, filt_d;

   // A bit's filtered value follows s2 only after it has differed for DEBOUNCE_CYCLES clocks
   always_comb begin
      filt_d = filt_q;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (s2_q[i] == filt_q[i]) begin
            cnt_d[i] = {CW{1'b0}};
         end else if (cnt_q[i] == CNT_LAST) begin
            filt_d[i] = s2_q[i];
            cnt_d[i]  = {CW{1'b0}};
         end else begin
            cnt_d[i] = cnt_q[i] + {{(CW-1){1'b0}}, 1'b1};
         end
      end
   end

   // Debounce counter and filter state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         filt_q <= {WIDTH{1'b0}};
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= {CW{1'b0}};
      end else begin
         filt_q <= filt_d;
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign cond_s = filt_q;
`else
   assign cond_s = s2_q;
`endif

   // Edge detect, register writes and next read word
   always_comb begin
      case (EDGE_TYPE)
         1:       edge_s = ~cond_s & prev_q;
         2:       edge_s = cond_s ^ prev_q;
         default: edge_s = cond_s & ~prev_q;
      endcase

      wr_en_s = chipselect & ~write_n;
      mask_d  = mask_q;
      ec_d    = ec_q;
      if (wr_en_s && address == 2'd2) begin
         mask_d = writedata[WIDTH-1:0];
      end else begin
         mask_d = mask_q;
      end
      // Clear is applied before the set so a simultaneous edge wins
      if (wr_en_s && address == 2'd3) begin
         ec_d = (ec_q & ~writedata[WIDTH-1:0]) | edge_s;
      end else begin
         ec_d = ec_q | edge_s;
      end

      rd_d = 32'd0;
      case (address)
         2'd0:    rd_d[WIDTH-1:0] = cond_s;
         2'd2:    rd_d[WIDTH-1:0] = mask_q;
         2'd3:    rd_d[WIDTH-1:0] = ec_q;
         default: rd_d = 32'd0;
      endcase
   end

   // Synchroniser, edge history and slave registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_q     <= {WIDTH{1'b0}};
         s2_q     <= {WIDTH{1'b0}};
         prev_q   <= {WIDTH{1'b0}};
         mask_q   <= {WIDTH{1'b0}};
         ec_q     <= {WIDTH{1'b0}};
         readdata <= 32'd0;
      end else begin
         s1_q     <= in_port;
         s2_q     <= s1_q;
         prev_q   <= cond_s;
         mask_q   <= mask_d;
         ec_q     <= ec_d;
         readdata <= rd_d;
      end
   end

   assign irq = |(ec_q & mask_q);

endmodule

// File: tb/tb_pio_in_edge.sv
// Directed bench for pio_in_edge: rising (main), falling and any-edge instances
// on a shared bus; debounce scenario only when PIO_IN_DEBOUNCE_EN is defined.
module tb_pio_in_edge;

`ifdef PIO_IN_DEBOUNCE_EN
   localparam int EXT = 4;
`else
   localparam int EXT = 0;
`endif

   logic        clk;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [7:0]  in_port, in_f, in_a;
   logic [31:0] rd, rd_f, rd_a;
   logic        irq, irq_f, irq_a;

   int n_vec;
   int n_err;

   pio_in_edge #(.WIDTH(8), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(4)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rd), .irq(irq));

   pio_in_edge #(.WIDTH(8), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(4)) dut_f (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_f),
      .readdata(rd_f), .irq(irq_f));

   pio_in_edge #(.WIDTH(8), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(4)) dut_a (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_a),
      .readdata(rd_a), .irq(irq_a));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b0;
      writedata  = d;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'd0;
   endtask

   task automatic read_reg(input logic [1:0] a);
      address = a;
      tick();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      ticks(3);
      n_vec++; if (rd !== 32'd0) begin n_err++; $display("FAIL reset_rd got %h want %h", rd, 32'd0); end
      n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b want 0", irq); end
      reset_n = 1'b1;
      in_port = 8'hFF;
      ticks(3 + EXT);
      bus_write(2'd2, 32'h0000_00FF);
      n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL pre_reset_irq got %b want 1", irq); end
      read_reg(2'd3);
      n_vec++; if (rd !== 32'h0000_00FF) begin n_err++; $display("FAIL pre_reset_ec got %h want %h", rd, 32'h0000_00FF); end
      #3 reset_n = 1'b0;
      #1;
      n_vec++; if (rd !== 32'd0) begin n_err++; $display("FAIL async_reset_rd got %h want %h", rd, 32'd0); end
      n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL async_reset_irq got %b want 0", irq); end
      in_port = 8'h00;
      tick();
      reset_n = 1'b1;
      read_reg(2'd2);
      n_vec++; if (rd !== 32'd0) begin n_err++; $display("FAIL post_reset_mask got %h want %h", rd, 32'd0); end
      read_reg(2'd3);
      n_vec++; if (rd !== 32'd0) begin n_err++; $display("FAIL post_reset_ec got %h want %h", rd, 32'd0); end
   endtask

   task automatic test_capture();
      address = 2'd3;
      in_port = 8'h05;
      ticks(3 + EXT);
      n_vec++; if (rd !== 32'd0) begin n_err++; $display("FAIL cap_early got %h want %h", rd, 32'd0); end
      tick();
      n_vec++; if (rd !== 32'h0000_0005) begin n_err++; $display("FAIL cap_ec got %h want %h", rd, 32'h5); end
      read_reg(2'd0);
      n_vec++; if (rd !== 32'h0000_0005) begin n_err++; $display("FAIL cap_data got %h want %h", rd, 32'h5); end
      n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL cap_irq_masked got %b want 0", irq); end
   endtask

   task automatic test_irq_clear();
      bus_write(2'd2, 32'h0000_0004);
      n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_after_mask got %b want 1", irq); end
      bus_write(2'd3, 32'h0000_0004);
      n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_after_w1c got %b want 0", irq); end
      read_reg(2'd3);
      n_vec++; if (rd !== 32'h0000_0001) begin n_err++; $display("FAIL ec_after_w1c got %h want %h", rd, 32'h1); end
      bus_write(2'd1, 32'h0000_00FF);
      read_reg(2'd1);
      n_vec++; if (rd !== 32'd0) begin n_err++; $display("FAIL reserved_read got %h want %h", rd, 32'd0); end
      read_reg(2'd2);
      n_vec++; if (rd !== 32'h0000_0004) begin n_err++; $display("FAIL mask_after_rsvd got %h want %h", rd, 32'h4); end
      read_reg(2'd3);
      n_vec++; if (rd !== 32'h0000_0001) begin n_err++; $display("FAIL ec_after_rsvd got %h want %h", rd, 32'h1); end
      address    = 2'd2;
      chipselect = 1'b0;
      write_n    = 1'b0;
      writedata  = 32'h0000_00FF;
      tick();
      write_n    = 1'b1;
      writedata  = 32'd0;
      read_reg(2'd2);
      n_vec++; if (rd !== 32'h0000_0004) begin n_err++; $display("FAIL mask_no_cs got %h want %h", rd, 32'h4); end
      bus_write(2'd2, 32'hFFFF_FF01);
      read_reg(2'd2);
      n_vec++; if (rd !== 32'h0000_0001) begin n_err++; $display("FAIL mask_upper_ignored got %h want %h", rd, 32'h1); end
      n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_bit0 got %b want 1", irq); end
      bus_write(2'd3, 32'h0000_00FF);
      n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_clear_all got %b want 0", irq); end
      read_reg(2'd3);
      n_vec++; if (rd !== 32'd0) begin n_err++; $display("FAIL ec_clear_all got %h want %h", rd, 32'd0); end
   endtask

   task automatic test_race();
      in_port = 8'h04;
      ticks(4 + EXT);
      read_reg(2'd3);
      n_vec++; if (rd !== 32'd0) begin n_err++; $display("FAIL no_fall_capture got %h want %h", rd, 32'd0); end
      in_port = 8'h05;
      ticks(2 + EXT);
      bus_write(2'd3, 32'h0000_0001);
      n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL race_irq got %b want 1", irq); end
      read_reg(2'd3);
      n_vec++; if (rd !== 32'h0000_0001) begin n_err++; $display("FAIL race_set_wins got %h want %h", rd, 32'h1); end
      bus_write(2'd3, 32'h0000_0001);
      read_reg(2'd3);
      n_vec++; if (rd !== 32'd0) begin n_err++; $display("FAIL race_later_clear got %h want %h", rd, 32'd0); end
   endtask

   task automatic test_edge_modes();
      in_f = 8'hFF;
      ticks(4 + EXT);
      bus_write(2'd3, 32'h0000_00FF);
      read_reg(2'd3);
      n_vec++; if (rd_f !== 32'd0) begin n_err++; $display("FAIL fall_idle got %h want %h", rd_f, 32'd0); end
      in_f = 8'hF0;
      ticks(4 + EXT);
      n_vec++; if (rd_f !== 32'h0000_000F) begin n_err++; $display("FAIL fall_capture got %h want %h", rd_f, 32'hF); end
      in_a = 8'h01;
      ticks(4 + EXT);
      n_vec++; if (rd_a !== 32'h0000_0001) begin n_err++; $display("FAIL any_rise got %h want %h", rd_a, 32'h1); end
      bus_write(2'd3, 32'h0000_0001);
      read_reg(2'd3);
      n_vec++; if (rd_a !== 32'd0) begin n_err++; $display("FAIL any_cleared got %h want %h", rd_a, 32'd0); end
      in_a = 8'h00;
      ticks(4 + EXT);
      n_vec++; if (rd_a !== 32'h0000_0001) begin n_err++; $display("FAIL any_fall got %h want %h", rd_a, 32'h1); end
   endtask

`ifdef PIO_IN_DEBOUNCE_EN
   task automatic test_debounce();
      in_port = 8'h00;
      ticks(12);
      bus_write(2'd3, 32'h0000_00FF);
      address = 2'd0;
      in_port = 8'h01;
      ticks(3);
      in_port = 8'h00;
      ticks(10);
      n_vec++; if (rd !== 32'd0) begin n_err++; $display("FAIL db_short_data got %h want %h", rd, 32'd0); end
      read_reg(2'd3);
      n_vec++; if (rd !== 32'd0) begin n_err++; $display("FAIL db_short_ec got %h want %h", rd, 32'd0); end
      address = 2'd0;
      in_port = 8'h01;
      ticks(4);
      in_port = 8'h00;
      ticks(3);
      n_vec++; if (rd !== 32'h0000_0001) begin n_err++; $display("FAIL db_hold_data got %h want %h", rd, 32'h1); end
      read_reg(2'd3);
      n_vec++; if (rd !== 32'h0000_0001) begin n_err++; $display("FAIL db_hold_ec got %h want %h", rd, 32'h1); end
   endtask
`endif

   initial begin
      n_vec      = 0;
      n_err      = 0;
      reset_n    = 1'b0;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'd0;
      in_port    = 8'h00;
      in_f       = 8'h00;
      in_a       = 8'h00;
      test_reset();
      test_capture();
      test_irq_clear();
      test_race();
      test_edge_modes();
`ifdef PIO_IN_DEBOUNCE_EN
      test_debounce();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pio_in_edge.md
PIO_IN_EDGE -- requirements
Module: pio_in_edge

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8: number of input bits, legal range 1..32.
REQ-002 The block SHALL take parameter EDGE_TYPE, default 0: capture edge, 0 = rising, 1 = falling, 2 = any.
REQ-003 The block SHALL take parameter DEBOUNCE_CYCLES, default 16: filter length, legal range 2..65535, used only when PIO_IN_DEBOUNCE_EN is defined.
REQ-004 The block SHALL have clk, input, 1: sole clock, all state on its rising edge.
REQ-005 The block SHALL have reset_n, input, 1: asynchronous active-low reset.
REQ-006 The block SHALL have address, input, 2: Avalon-MM slave word address.
REQ-007 The block SHALL have chipselect, input, 1: slave select.
REQ-008 The block SHALL have write_n, input, 1: active-low write strobe.
REQ-009 The block SHALL have writedata, input, 32: write data.
REQ-010 The block SHALL have in_port, input, WIDTH: asynchronous external inputs.
REQ-011 The block SHALL have readdata, output, 32: registered read data.
REQ-012 The block SHALL have irq, output, 1: level interrupt.

Function
REQ-013 in_port SHALL pass through a 2-flop synchronizer (s1, then s2) per bit; the conditioned value "cond" SHALL be s2, or the debounce output when PIO_IN_DEBOUNCE_EN is defined.
REQ-014 A register prev SHALL hold cond delayed one clock.
REQ-015 Per-bit edge SHALL be: cond & ~prev for EDGE_TYPE 0; ~cond & prev for EDGE_TYPE 1; cond ^ prev for EDGE_TYPE 2.
REQ-016 The register map SHALL be: addr 0 = data (RO, cond); addr 1 = reserved (reads 0, writes ignored); addr 2 = interruptmask (RW, WIDTH bits); addr 3 = edgecapture (read; write-1-to-clear).
REQ-017 A write SHALL occur on any clock where chipselect=1 and write_n=0; bits of writedata above WIDTH-1 SHALL be ignored.
REQ-018 readdata SHALL be loaded every clock with the register selected by address, zero-extended to 32 bits, regardless of chipselect (1-cycle read latency).
REQ-019 An edgecapture bit SHALL set on the clock after its edge term is true and hold until cleared by a write of 1 to that bit at addr 3.
REQ-020 If a set and a clear of the same edgecapture bit occur in the same clock, the set SHALL win.
REQ-021 irq SHALL equal the OR of (edgecapture & interruptmask), driven from registers only (glitch-free).
REQ-022 Latency without debounce: in_port sampled at edge k SHALL appear in s2 at edge k+1, in edgecapture/irq at edge k+2, and in readdata (addr 0) at edge k+2.

Reset
REQ-023 On reset_n=0, s1, s2, prev, interruptmask, edgecapture, and readdata SHALL clear to 0 and irq SHALL be 0, asynchronously.
REQ-024 With debounce, the per-bit counters and filtered outputs SHALL clear to 0.
REQ-025 Input transitions present at reset release SHALL be treated as new edges against prev=0.

Configuration
REQ-026 With PIO_IN_DEBOUNCE_EN defined, each bit SHALL carry a counter of width clog2(DEBOUNCE_CYCLES).
- Counter clears whenever s2 == filt.
- Otherwise it increments.
- When it equals DEBOUNCE_CYCLES-1 and s2 != filt, filt <= s2 and the counter clears.
- A transition at s2 on edge k+1 reaches filt at edge k+1+DEBOUNCE_CYCLES.
- Shorter pulses are discarded.
REQ-027 Without PIO_IN_DEBOUNCE_EN, no counters SHALL be synthesised, cond SHALL equal s2, and DEBOUNCE_CYCLES SHALL have no effect.

Verification (WIDTH=8, EDGE_TYPE=0 unless noted)
REQ-028 Reset: assert reset_n=0 mid-operation with edgecapture=0xFF and mask=0xFF -> readdata=0, irq=0 immediately; after release, addr 2 and addr 3 read 0x00000000.
REQ-029 Capture: in_port 0x00->0x05 at edge k, address=3 -> readdata=0x00000005 from edge k+3; address=0 -> 0x00000005; irq stays 0 (mask=0).
REQ-030 Interrupt and clear: write mask 0x04 -> irq=1 the clock after the write; write 0x04 to addr 3 -> edgecapture=0x01, irq=0; write 0xFF to addr 1 -> no register changes.
REQ-031 Set/clear race: bit0 rising edge term true in the same clock as a W1C of 0x01 -> bit0 remains 1.
REQ-032 Falling/any mode: EDGE_TYPE=1 with in_port 0xFF->0xF0 -> edgecapture=0x0F; EDGE_TYPE=2 with 0x00->0x01->0x00 -> bit0 set after each transition.
REQ-033 Debounce (macro defined, DEBOUNCE_CYCLES=4): a 3-cycle pulse on bit0 -> data and edgecapture remain 0; a 4-cycle hold -> data bit0=1 and edgecapture=0x01.
